// File: rtl/dither_stream.sv
// Streaming colour quantiser: truncate, round, 4x4 Bayer or line error diffusion.
// Ports: clk, rst_n, mode, s_data/s_valid/s_sof/s_ready in, m_data/m_valid/m_eol/m_ready out.
module dither_stream #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 4,
  parameter int CHANNELS = 3,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*IN_W-1:0]  s_data,
  input  logic                      s_valid,
  input  logic                      s_sof,
  output logic                      s_ready,
  output logic [CHANNELS*OUT_W-1:0] m_data,
  output logic                      m_valid,
  output logic                      m_eol,
  input  logic                      m_ready
);

  localparam int D   = IN_W - OUT_W;
  localparam int XW  = $clog2(H_RES);
  localparam int YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int SHL = (D >= 4) ? D - 4 : 0;
  localparam int SHR = (D >= 4) ? 0 : 4 - D;

  localparam logic [OUT_W-1:0] MAX    = '1;
  localparam logic [XW-1:0]    X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(V_RES - 1);

  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  typedef enum logic [1:0] {
    M_TRUNC = 2'd0,
    M_ROUND = 2'd1,
    M_ORD   = 2'd2,
    M_DIFF  = 2'd3
  } mode_e;

  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [1:0]    bx, by;
  logic [3:0]    b;
  logic [D-1:0]  t;
  logic          acc, last;

  logic [CHANNELS-1:0][D-1:0] e, e_nxt;
  logic [CHANNELS*OUT_W-1:0]  q;

  logic [IN_W-1:0]  c;
  logic [OUT_W-1:0] hi, qc;
  logic [D-1:0]     lo, e_in, en;
  logic [IN_W:0]    sum;

  function automatic logic [OUT_W-1:0] sat_inc(
    input logic [OUT_W-1:0] h,
    input logic             inc
  );
    return (inc && h != MAX) ? h + OUT_W'(1) : h;
  endfunction

  assign s_ready = !m_valid || m_ready;
  assign acc     = s_valid && s_ready;

  // A start-of-frame pixel is placed at the origin regardless of counters.
  assign px   = s_sof ? '0 : x;
  assign py   = s_sof ? '0 : y;
  assign last = (px == X_LAST);

  assign bx = 2'(px);
  assign by = 2'(py);
  assign b  = BAYER[{by, bx}];
  // Scale the 4-bit Bayer entry to the D-bit fraction range.
  assign t  = D'((32'(b) << SHL) >> SHR);

  always_comb begin
    q     = '0;
    e_nxt = '0;
    c     = '0;
    hi    = '0;
    lo    = '0;
    e_in  = '0;
    sum   = '0;
    qc    = '0;
    en    = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      c    = s_data[ch*IN_W +: IN_W];
      hi   = c[IN_W-1:D];
      lo   = c[D-1:0];
      // Error never carries across a line start.
      e_in = (px == '0) ? '0 : e[ch];
      sum  = {1'b0, c} + (IN_W+1)'(e_in);
      qc   = hi;
      en   = '0;
      unique case (mode_e'(mode))
        M_TRUNC: qc = hi;
        M_ROUND: qc = sat_inc(hi, lo[D-1]);
        M_ORD:   qc = sat_inc(hi, lo > t);
        M_DIFF: begin
          if (sum[IN_W]) begin
            qc = MAX;
          end else begin
            qc = sum[IN_W-1:D];
            en = sum[D-1:0];
          end
        end
      endcase
      q[ch*OUT_W +: OUT_W] = qc;
      e_nxt[ch]            = en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_eol   <= 1'b0;
      x       <= '0;
      y       <= '0;
      e       <= '0;
    end else if (acc) begin
      m_data  <= q;
      m_eol   <= last;
      m_valid <= 1'b1;
      e       <= e_nxt;
      if (last) begin
        x <= '0;
        y <= (py == Y_LAST) ? '0 : py + YW'(1);
      end else begin
        x <= px + XW'(1);
        y <= py;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dither_stream.sv
// Bench for dither_stream: vector table, directed corner sequences, random scoreboard.
// Drives all ports of a small 8x4 frame instance.
module tb_dither_stream;

  localparam int IN_W = 8;
  localparam int OUT_W = 4;
  localparam int CH = 3;
  localparam int H_RES = 8;
  localparam int V_RES = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode = '0;
  logic [23:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          s_ready;
  logic [11:0]   m_data;
  logic          m_valid;
  logic          m_eol;
  logic          m_ready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  dither_stream #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH),
    .H_RES(H_RES), .V_RES(V_RES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_eol(m_eol), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [23:0] d;
    logic        sof;
    logic [11:0] q;
    logic        eol;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] md, input logic [23:0] d,
                     input logic sof, input logic [11:0] q,
                     input logic eol);
    vec_t v;
    v.md = md; v.d = d; v.sof = sof; v.q = q; v.eol = eol;
    tv.push_back(v);
  endtask

  // Single accepted pixel with m_ready held high; check one cycle later.
  task automatic push(input string nm, input logic [1:0] md,
                      input logic [23:0] d, input logic sof,
                      input logic [11:0] q, input logic eol);
    mode = md; s_data = d; s_sof = sof; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    chk({nm, " valid"}, 32'(m_valid), 32'd1);
    chk({nm, " data"}, 32'(m_data), 32'(q));
    chk({nm, " eol"}, 32'(m_eol), 32'(eol));
  endtask

  // Reference model state
  int mx = 0, my = 0;
  int me[CH];
  int bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  task automatic model(input logic [1:0] md, input logic [23:0] d,
                       input logic sf, output logic [11:0] q,
                       output logic eol);
    int px, py, cv, hi, lo, qq, ee, s, ne;
    px = sf ? 0 : mx;
    py = sf ? 0 : my;
    q = '0;
    for (int k = 0; k < CH; k++) begin
      cv = int'(d[k*8 +: 8]);
      hi = cv / 16;
      lo = cv % 16;
      ne = 0;
      case (md)
        2'd0: qq = hi;
        2'd1: qq = hi + ((lo >= 8) ? 1 : 0);
        2'd2: qq = hi + ((lo > bay[(py % 4) * 4 + (px % 4)]) ? 1 : 0);
        default: begin
          ee = (px == 0) ? 0 : me[k];
          s = cv + ee;
          if (s >= 256) begin
            qq = 15;
          end else begin
            qq = s / 16;
            ne = s % 16;
          end
        end
      endcase
      if (qq > 15) qq = 15;
      q[k*4 +: 4] = 4'(qq);
      me[k] = (md == 2'd3) ? ne : 0;
    end
    eol = (px == H_RES - 1);
    if (px == H_RES - 1) begin
      mx = 0;
      my = (py == V_RES - 1) ? 0 : py + 1;
    end else begin
      mx = px + 1;
      my = py;
    end
  endtask

  initial begin
    logic [11:0] eq, rq;
    logic        ee, exp_v, reol;
    int          got, cyc;

    // Vector table
    add(2'd0, 24'hAB12FF, 1'b1, 12'hA1F, 1'b0);
    add(2'd1, 24'hF87778, 1'b0, 12'hF78, 1'b0);
    for (int i = 0; i < 8; i++)
      add(2'd2, 24'h474747, i == 0,
          (i % 2 == 0) ? 12'h555 : 12'h444, i == 7);
    for (int i = 0; i < 8; i++)
      add(2'd2, 24'h474747, 1'b0,
          (i % 2 == 0) ? 12'h444 : 12'h555, i == 7);
    for (int i = 0; i < 8; i++)
      add(2'd3, 24'h484848, i == 0,
          (i % 2 == 0) ? 12'h444 : 12'h555, i == 7);
    add(2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h555, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    add(2'd3, 24'h484848, 1'b1, 12'h444, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h555, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    add(2'd1, 24'h484848, 1'b0, 12'h555, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    add(2'd3, 24'hFFFFFF, 1'b0, 12'hFFF, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    add(2'd3, 24'h484848, 1'b0, 12'h555, 1'b1);

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(m_valid), 32'd0);
    chk("rst data", 32'(m_data), 32'd0);
    chk("rst eol", 32'(m_eol), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    foreach (tv[i])
      push($sformatf("vec%0d", i), tv[i].md, tv[i].d, tv[i].sof,
           tv[i].q, tv[i].eol);

    // Backpressure during mode 3
    push("bp0", 2'd3, 24'h484848, 1'b1, 12'h444, 1'b0);
    push("bp1", 2'd3, 24'h484848, 1'b0, 12'h555, 1'b0);
    s_valid = 1'b1;
    m_ready = 1'b0;
    #1;
    chk("bp s_ready comb", 32'(s_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp hold data", 32'(m_data), 32'h555);
      chk("bp hold valid", 32'(m_valid), 32'd1);
      chk("bp s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp rel0", 32'(m_data), 32'h444);
    @(posedge clk); #1;
    chk("bp rel1", 32'(m_data), 32'h555);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp drain valid", 32'(m_valid), 32'd0);

    // Asynchronous reset mid-line with m_valid high
    mode = 2'd3; s_data = 24'h484848; s_sof = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    s_sof = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("mid valid", 32'(m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", 32'(m_valid), 32'd0);
    chk("async data", 32'(m_data), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    push("post rst0", 2'd3, 24'h484848, 1'b0, 12'h444, 1'b0);
    push("post rst1", 2'd3, 24'h484848, 1'b0, 12'h555, 1'b0);
    @(posedge clk); #1;

    // Random valid/ready against the model
    exp_v = 1'b0;
    eq = '0;
    ee = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 200 && cyc < 3000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      s_data = 24'($urandom);
      s_sof = (got == 0) || ($urandom_range(0, 15) == 0);
      #1;
      chk("rnd valid", 32'(m_valid), 32'(exp_v));
      if (m_valid && m_ready) begin
        chk("rnd data", 32'(m_data), 32'(eq));
        chk("rnd eol", 32'(m_eol), 32'(ee));
        exp_v = 1'b0;
      end
      if (s_valid && s_ready) begin
        model(mode, s_data, s_sof, rq, reol);
        eq = rq;
        ee = reol;
        exp_v = 1'b1;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < 200) chk("rnd timeout", 32'(got), 32'd200);
    s_valid = 1'b0;
    s_sof = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("rnd last valid", 32'(m_valid), 32'(exp_v));
    if (m_valid) begin
      chk("rnd last data", 32'(m_data), 32'(eq));
      chk("rnd last eol", 32'(m_eol), 32'(ee));
    end
    @(posedge clk); #1;
    chk("rnd idle", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
